// File: rtl/mem_bus_pkg.sv
// Shared types for the memory data-port arbiter.
// Default widths, arbiter states and read-return tags.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_rd_tag_pipe.sv
// Read-return tag delay line, RD_LAT stages deep.
// The head stage lines up with mem_rdata of the issuing beat.
module rd_tag_pipe
    import mem_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t head_o
);

    rd_tag_t [RD_LAT-1:0] pipe_q;

    // Shift tags toward the head; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign head_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter for the memory controller data port.
// Round-robin, beat locking with watchdog, read-return routing.
module mem_arb
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic             lock_err_q, lock_err_d;

    logic             gnt0, gnt1;
    logic             acc, acc_we, acc_lock, own_req;
    logic [CNT_W-1:0] cnt_inc;
    rd_tag_t          tag_in, tag_head;

    // Grant selection; a locked owner excludes the other side.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            ST_LOCK0: gnt0 = r0_req;
            ST_LOCK1: gnt1 = r1_req;
            default: begin
                gnt0 = r0_req && (!r1_req || last_gnt_q);
                gnt1 = r1_req && (!r0_req || !last_gnt_q);
            end
        endcase
        gnt0 = gnt0 && rst_n;
        gnt1 = gnt1 && rst_n;
    end

    assign acc      = gnt0 || gnt1;
    assign acc_we   = gnt1 ? r1_we : r0_we;
    assign acc_lock = gnt1 ? r1_lock : r0_lock;
    assign own_req  = (state_q == ST_LOCK1) ? r1_req : r0_req;
    assign cnt_inc  = lock_cnt_q + CNT_W'(1);

    // Next state: lock entry/exit, beat counting and watchdog release.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_gnt_d = last_gnt_q;
        lock_err_d = 1'b0;
        if (acc) begin
            last_gnt_d = gnt1;
        end
        unique case (state_q)
            ST_LOCK0, ST_LOCK1: begin
                if (!own_req || !acc_lock) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (cnt_inc == CNT_W'(MAX_LOCK)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    lock_err_d = 1'b1;
                end else begin
                    lock_cnt_d = cnt_inc;
                end
            end
            default: begin
                if (acc && acc_lock) begin
                    state_d    = gnt1 ? ST_LOCK1 : ST_LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end
            end
        endcase
    end

    // Arbiter state registers; requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_gnt_q <= last_gnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Pass the granted beat straight through to memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (gnt0) begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_we    = r0_we;
            mem_re    = !r0_we;
        end else if (gnt1) begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_we    = r1_we;
            mem_re    = !r1_we;
        end
    end

    assign tag_in.valid = acc && !acc_we;
    assign tag_in.id    = gnt1;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tags (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_i  (tag_in),
        .head_o (tag_head)
    );

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = tag_head.valid && !tag_head.id;
    assign r1_rvalid = tag_head.valid && tag_head.id;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;
    assign lock_err  = lock_err_q;

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-requester arbiter sharing the single data port of the memory controller.
- Requester 0 is the core data port; requester 1 is the loader/debug port.
- Provides round-robin arbitration, multi-beat locking with a forced-release watchdog, and read-return routing over a fixed-latency memory.
- Sits between the requesters and the memory controller's addr/data/we interface.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles (≥1); mem_rdata is valid RD_LAT cycles after a read beat
- MAX_LOCK, 16, maximum consecutive locked beats before forced release (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 beat request
- r0_we  in  1  1 = write beat, 0 = read beat
- r0_lock  in  1  hold ownership after this beat
- r0_addr  in  ADDR_W  beat address
- r0_wdata  in  DATA_W  write data
- r0_gnt  out  1  beat accepted this cycle
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  DATA_W  read data
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_*, for requester 1
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, RD_LAT after mem_re
- lock_err  out  1  one-cycle pulse on forced lock release

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all registers clear; last_gnt = 1, so requester 0 wins the first tie.
- Outputs while rst_n = 0: all outputs 0.
- Beat acceptance: a beat is accepted when rN_req && rN_gnt.
  - rN_gnt is combinational from state and requests.
  - At most one gnt is high per cycle.
- Memory port on an accepted beat (combinational pass-through of the granted requester, same cycle):
  - mem_addr and mem_wdata come from the granted requester.
  - mem_we = we; mem_re = !we.
  - With no grant: mem_addr, mem_wdata, mem_we and mem_re are all 0.
- Arbitration state machine:
  - IDLE (no owner):
    - Exactly one request: grant it.
    - Both request: grant !last_gnt.
    - last_gnt updates on every accepted beat.
    - Accepted beat with lock = 1: go to LOCKED(owner), lock_cnt = 1.
  - LOCKED(owner):
    - Only the owner can be granted; the other gnt is held at 0.
    - Owner accepted beat with lock = 0: return to IDLE.
    - Owner deasserts req: return to IDLE the next cycle, no grant that cycle.
    - Each accepted locked beat increments lock_cnt.
- Forced release (watchdog):
  - Triggered when the owner's accepted beat would make lock_cnt = MAX_LOCK with lock still 1.
  - The beat completes normally.
  - State returns to IDLE, lock_err pulses 1 the following cycle, and last_gnt = owner.
  - Result: the other requester wins the next tie.
- Read return:
  - RD_LAT-deep shift register of {valid, id} entries, loaded on each accepted read beat.
  - At the output stage, r[id]_rvalid = 1; r[id]_rdata = mem_rdata for the matching id, 0 otherwise.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle.
  - Writes produce no rvalid.
- Grants do not depend on read-return occupancy; the pipeline is fully throughput-1.
- Reset asserted mid-operation:
  - In-flight read tags are discarded; no rvalid after reset.
  - Lock state is dropped and lock_cnt is cleared.
- Undefined requests: requests with X on req are not required to be handled; the bench drives legal values only.

Decomposition:
- Shared package mem_bus_pkg:
  - ADDR_W and DATA_W defaults
  - state enum {ST_IDLE, ST_LOCK0, ST_LOCK1}
  - tag struct {valid, id}
- Sub-module rd_tag_pipe:
  - Parameterised RD_LAT shift register of tags.
  - Asynchronous clear on rst_n.
  - Outputs the head tag.
- Arbitration FSM, lock counter and port muxing stay in mem_arb.

Test Plan:
1. Reset then idle: hold rst_n = 0 for 3 cycles, release with no requests -> all gnt, rvalid, mem_we, mem_re and lock_err = 0; mem_addr = 0.
2. Single read: r0 reads addr 0x10, memory returns 0xDEADBEEF, RD_LAT = 1 -> r0_gnt = 1 in cycle t; mem_re = 1 with mem_addr = 0x10 in t; r0_rvalid = 1, r0_rdata = 0xDEADBEEF in t+1; r1_rvalid stays 0.
3. Round-robin: both request non-locked writes continuously for 4 cycles from reset -> grants r0, r1, r0, r1; mem_we = 1 every cycle with matching addr/wdata.
4. Lock hold: r1 locks 3 beats (lock = 1,1,0) while r0 requests continuously -> r1 granted 3 consecutive cycles, r0_gnt = 0 throughout; r0 granted on the 4th cycle.
5. Forced release: MAX_LOCK = 4, r0 holds lock = 1 indefinitely, r1 requesting -> r0 granted 4 beats; lock_err = 1 on the next cycle; r1 granted next.
6. Reset mid-read: RD_LAT = 3, r1 issues reads at t, t+1; rst_n = 0 at t+2 -> no r1_rvalid ever asserts; after release, r0 is granted first on a tie.
